instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have one clock, clk, and a synchronous active-high reset, reset; no other clock or reset inputs.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port dbus, input, 8 bits: memory data (opcode or operand byte).
REQ-005 SHALL have port flags, input, 3 bits: {N,C,Z}, with flags[0]=Z, flags[1]=C, flags[2]=N.
REQ-006 SHALL have port pc_outn, output, 1 bit: active-low request for the program counter to drive abus.
REQ-007 SHALL have port pc_count, output, 1 bit: active-high program counter increment enable.
REQ-008 SHALL have port pc_loadn, output, 1 bit: active-low program counter load from abus.
REQ-009 SHALL have port mem_rdn, output, 1 bit: active-low memory read onto dbus.
REQ-010 SHALL have port addr, output, 16 bits: jump target {hi,lo} for abus.
REQ-011 SHALL have port addr_oen, output, 1 bit: active-low enable that gates addr onto abus.
REQ-012 SHALL have port opcode, output, 8 bits: instruction register contents.
REQ-013 SHALL have port step, output, 3 bits: current microstep.
REQ-014 SHALL have port halted, output, 1 bit: high while halted.

Function
REQ-015 All control outputs SHALL decode only from registered state (step, opcode, halted), plus flags where REQ-022 says so; no dbus-to-output path.
REQ-016 Step 0 (FETCH) SHALL set pc_outn=0, mem_rdn=0, pc_count=1; at the edge, opcode<=dbus and step<=1.
REQ-017 Class A, opcode[7:6]=00 or opcode[7:6]=11 except 0xFF: step 1 SHALL assert no controls; next step=0.
REQ-018 Class I, opcode[7:6]=01: step 1 SHALL set pc_outn=0, mem_rdn=0, pc_count=1 (operand fetch); next step=0.
REQ-019 Class J, opcode[7:6]=10, step 1: controls as REQ-018; lo<=dbus at the edge.
REQ-020 Class J, step 2: controls as REQ-018; hi<=dbus at the edge.
REQ-021 Class J, step 3: next step=0.
REQ-022 Class J, step 3 condition: opcode[1:0] selects the source (00 always-true, 01 Z, 10 C, 11 N); opcode[2]=1 inverts it.
REQ-023 Class J, step 3 taken: addr_oen=0 and pc_loadn=0, so the program counter loads {hi,lo} at the edge.
REQ-024 Class J, step 3 not taken: no controls asserted.
REQ-025 Class J, step 3: flags SHALL be sampled combinationally during that cycle.
REQ-026 addr SHALL always equal {hi,lo}; it is valid on abus only while addr_oen=0.
REQ-027 addr_oen=0 and pc_outn=0 SHALL never occur in the same cycle.
REQ-028 Opcode 0xFF, step 1: halted<=1 at the edge. While halted: step=0, all controls inactive, opcode held, dbus ignored.
REQ-029 The halted state SHALL be exited only by reset.
REQ-030 step SHALL never exceed 3; any unreachable value SHALL return to 0 on the next edge with controls inactive.
REQ-031 Instruction lengths: Class A 2 cycles, Class I 2 cycles, Class J 4 cycles.

Reset
REQ-032 While reset=1 at an edge: step<=0, opcode<=0x00, lo<=0x00, hi<=0x00, halted<=0.
REQ-033 Outputs following reset: pc_outn=1, pc_count=0, pc_loadn=1, mem_rdn=1, addr_oen=1, addr=0x0000.
REQ-034 Reset SHALL override all activity (mid-instruction, mid-jump, halted); no partial lo/hi update survives.
REQ-035 The first cycle after reset deassertion SHALL be FETCH (step 0).

Verification
REQ-036 Reset, then dbus=0x12 at FETCH -> opcode=0x12; step sequence 0,1,0; pc_count high only in step 0.
REQ-037 dbus sequence 0x80,0x34,0x12 -> step 3 shows addr=0x1234, addr_oen=0, pc_loadn=0; step returns to 0.
REQ-038 Opcode 0x81 with flags=3'b000 -> step 3 pc_loadn=1, addr_oen=1 (not taken). Opcode 0x85 with flags=3'b000 -> taken.
REQ-039 Opcode 0x45 -> step 1 pc_count=1, mem_rdn=0; total 2 cycles; opcode stays 0x45 until the next FETCH.
REQ-040 Opcode 0xFF -> halted=1 after step 1; 10 further cycles keep step=0 and all controls inactive; reset -> halted=0, FETCH.
REQ-041 Reset asserted during step 2 of opcode 0x80 -> next cycle opcode=0x00, addr=0x0000, step=0, no pc_loadn pulse.

Source files
------------

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - microstep sequencer for a byte-wide instruction fetch/decode unit
//
// Purpose: fetches an opcode byte, optionally one or two operand bytes, and
// drives program-counter / memory / address-bus controls for a simple
// three-class instruction set (A: no operand, I: one operand, J: two-byte
// conditional jump target). Opcode 0xFF halts until reset.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   dbus     in   [7:0] memory data (opcode or operand byte)
//   flags    in   [2:0] {N,C,Z}
//   pc_outn  out  active-low: program counter drives abus
//   pc_count out  active-high: program counter increment
//   pc_loadn out  active-low: program counter loads from abus
//   mem_rdn  out  active-low: memory read onto dbus
//   addr     out  [15:0] jump target {hi,lo}
//   addr_oen out  active-low: gate addr onto abus
//   opcode   out  [7:0] instruction register
//   step     out  [2:0] current microstep
//   halted   out  high while halted

module instruction_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  dbus,
  input  logic [2:0]  flags,
  output logic        pc_outn,
  output logic        pc_count,
  output logic        pc_loadn,
  output logic        mem_rdn,
  output logic [15:0] addr,
  output logic        addr_oen,
  output logic [7:0]  opcode,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [7:0] OP_HALT = 8'hFF;

  logic [2:0] step_q,   step_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] lo_q,     lo_d;
  logic [7:0] hi_q,     hi_d;
  logic       halted_q, halted_d;

  logic is_i;
  logic is_j;
  logic cond_src;
  logic cond;
  logic fetch_ctl;
  logic take_jump;

  assign is_i = (opcode_q[7:6] == 2'b01);
  assign is_j = (opcode_q[7:6] == 2'b10);

  // Jump condition source: 00 always, 01 Z, 10 C, 11 N; opcode[2] inverts.
  always_comb begin
    cond_src = 1'b1;
    case (opcode_q[1:0])
      2'b00:   cond_src = 1'b1;
      2'b01:   cond_src = flags[0];
      2'b10:   cond_src = flags[1];
      default: cond_src = flags[2];
    endcase
  end

  assign cond = cond_src ^ opcode_q[2];

  // Controls decode from registered state only (flags enter solely through
  // the jump condition). Reset masks them so nothing fires while held.
  always_comb begin
    fetch_ctl = 1'b0;
    take_jump = 1'b0;
    if (!reset && !halted_q) begin
      case (step_q)
        3'd0:    fetch_ctl = 1'b1;
        3'd1:    fetch_ctl = is_i | is_j;
        3'd2:    fetch_ctl = is_j;
        3'd3:    take_jump = is_j & cond;
        default: begin
          fetch_ctl = 1'b0;
          take_jump = 1'b0;
        end
      endcase
    end
  end

  // Next-state logic. Any step/opcode combination that cannot be reached
  // through normal sequencing falls back to FETCH.
  always_comb begin
    step_d   = step_q;
    opcode_d = opcode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = 3'd0;
    end else begin
      case (step_q)
        3'd0: begin
          opcode_d = dbus;
          step_d   = 3'd1;
        end
        3'd1: begin
          if (opcode_q == OP_HALT) begin
            halted_d = 1'b1;
            step_d   = 3'd0;
          end else if (is_j) begin
            lo_d   = dbus;
            step_d = 3'd2;
          end else begin
            step_d = 3'd0;
          end
        end
        3'd2: begin
          if (is_j) begin
            hi_d   = dbus;
            step_d = 3'd3;
          end else begin
            step_d = 3'd0;
          end
        end
        default: step_d = 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= 3'd0;
      opcode_q <= 8'h00;
      lo_q     <= 8'h00;
      hi_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      opcode_q <= opcode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      halted_q <= halted_d;
    end
  end

  assign pc_outn  = ~fetch_ctl;
  assign mem_rdn  = ~fetch_ctl;
  assign pc_count = fetch_ctl;
  assign pc_loadn = ~take_jump;
  assign addr_oen = ~take_jump;
  assign addr     = {hi_q, lo_q};
  assign opcode   = opcode_q;
  assign step     = step_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer

module tb_instruction_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  dbus;
  logic [2:0]  flags;
  logic        pc_outn;
  logic        pc_count;
  logic        pc_loadn;
  logic        mem_rdn;
  logic [15:0] addr;
  logic        addr_oen;
  logic [7:0]  opcode;
  logic [2:0]  step;
  logic        halted;

  int checks;
  int failures;

  instruction_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .dbus     (dbus),
    .flags    (flags),
    .pc_outn  (pc_outn),
    .pc_count (pc_count),
    .pc_loadn (pc_loadn),
    .mem_rdn  (mem_rdn),
    .addr     (addr),
    .addr_oen (addr_oen),
    .opcode   (opcode),
    .step     (step),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [2:0] fl;
    int         exp_len;
    logic       exp_taken;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules written directly from the instruction-set description.
  function automatic int ref_len(input logic [7:0] op);
    return (op[7:6] == 2'b10) ? 4 : 2;
  endfunction

  function automatic logic ref_has_operand(input logic [7:0] op);
    return (op[7:6] == 2'b01) || (op[7:6] == 2'b10);
  endfunction

  function automatic logic ref_taken(input logic [7:0] op, input logic [2:0] fl);
    int   sel;
    logic src;
    sel = int'(op[1:0]);
    src = (sel == 0) ? 1'b1 : fl[sel-1];
    return src ^ op[2];
  endfunction

  // Expected control bundle: {pc_outn, mem_rdn, pc_count, pc_loadn, addr_oen}
  function automatic logic [4:0] ctl_fetch();
    return 5'b00111;
  endfunction
  function automatic logic [4:0] ctl_idle();
    return 5'b11011;
  endfunction
  function automatic logic [4:0] ctl_jump();
    return 5'b11000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag, input logic [2:0] exp_step, input logic [4:0] exp_ctl);
    @(negedge clk);
    check({tag, ".step"}, 32'(step), 32'(exp_step));
    check({tag, ".ctl"}, 32'({pc_outn, mem_rdn, pc_count, pc_loadn, addr_oen}), 32'(exp_ctl));
    if (!addr_oen && !pc_outn) check({tag, ".abus_conflict"}, 32'd1, 32'd0);
  endtask

  // Drives one whole instruction and checks every cycle against expectations.
  task automatic run_instr(input vec_t v);
    dbus  = v.op;
    flags = 3'($urandom);
    sample("fetch", 3'd0, ctl_fetch());
    tick();
    dbus  = v.b1;
    flags = 3'($urandom);
    sample("s1", 3'd1, (v.exp_len == 4 || ref_has_operand(v.op)) ? ctl_fetch() : ctl_idle());
    check("s1.opcode", 32'(opcode), 32'(v.op));
    tick();
    if (v.exp_len == 4) begin
      dbus  = v.b2;
      flags = 3'($urandom);
      sample("s2", 3'd2, ctl_fetch());
      tick();
      dbus  = 8'($urandom);
      flags = v.fl;
      sample("s3", 3'd3, v.exp_taken ? ctl_jump() : ctl_idle());
      check("s3.addr", 32'(addr), 32'({v.b2, v.b1}));
      tick();
    end
    check("end.step", 32'(step), 32'd0);
    check("end.opcode", 32'(opcode), 32'(v.op));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst.step", 32'(step), 32'd0);
    check("rst.opcode", 32'(opcode), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.addr", 32'(addr), 32'd0);
    check("rst.ctl", 32'({pc_outn, mem_rdn, pc_count, pc_loadn, addr_oen}), 32'(ctl_idle()));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    dbus     = 8'h00;
    flags    = 3'b000;
    tick();
    do_reset();

    vecs.push_back('{8'h12, 8'hAA, 8'h00, 3'b000, 2, 1'b0});
    vecs.push_back('{8'h45, 8'h99, 8'h00, 3'b000, 2, 1'b0});
    vecs.push_back('{8'h80, 8'h34, 8'h12, 3'b000, 4, 1'b1});
    vecs.push_back('{8'h81, 8'h01, 8'h02, 3'b000, 4, 1'b0});
    vecs.push_back('{8'h85, 8'h03, 8'h04, 3'b000, 4, 1'b1});
    vecs.push_back('{8'h81, 8'h05, 8'h06, 3'b001, 4, 1'b1});
    vecs.push_back('{8'h82, 8'h07, 8'h08, 3'b010, 4, 1'b1});
    vecs.push_back('{8'h82, 8'h09, 8'h0A, 3'b101, 4, 1'b0});
    vecs.push_back('{8'h86, 8'h0B, 8'h0C, 3'b101, 4, 1'b1});
    vecs.push_back('{8'h83, 8'hCD, 8'hAB, 3'b100, 4, 1'b1});
    vecs.push_back('{8'h87, 8'hEF, 8'hBE, 3'b100, 4, 1'b0});
    vecs.push_back('{8'h84, 8'h11, 8'h22, 3'b111, 4, 1'b0});
    vecs.push_back('{8'hC3, 8'h55, 8'h00, 3'b000, 2, 1'b0});
    vecs.push_back('{8'hFE, 8'h55, 8'h00, 3'b000, 2, 1'b0});
    vecs.push_back('{8'h3F, 8'h66, 8'h00, 3'b000, 2, 1'b0});
    foreach (vecs[i]) run_instr(vecs[i]);

    // Random instruction stream against the rule-based reference.
    for (int n = 0; n < 300; n++) begin
      v.op = 8'($urandom);
      if (v.op == 8'hFF) v.op = 8'h00;
      v.b1        = 8'($urandom);
      v.b2        = 8'($urandom);
      v.fl        = 3'($urandom);
      v.exp_len   = ref_len(v.op);
      v.exp_taken = (v.exp_len == 4) ? ref_taken(v.op, v.fl) : 1'b0;
      run_instr(v);
    end

    // Halt: ten idle cycles, dbus ignored, then reset recovers.
    dbus = 8'hFF;
    sample("h.fetch", 3'd0, ctl_fetch());
    tick();
    dbus = 8'h45;
    sample("h.s1", 3'd1, ctl_idle());
    tick();
    for (int k = 0; k < 10; k++) begin
      dbus = 8'($urandom);
      sample("h.idle", 3'd0, ctl_idle());
      check("h.halted", 32'(halted), 32'd1);
      check("h.opcode", 32'(opcode), 32'hFF);
      tick();
    end
    do_reset();
    check("h.exit", 32'(halted), 32'd0);
    v = '{8'h12, 8'h00, 8'h00, 3'b000, 2, 1'b0};
    run_instr(v);

    // Reset during step 2 of a jump: no partial target, no load pulse.
    dbus = 8'h80;
    sample("r.fetch", 3'd0, ctl_fetch());
    tick();
    dbus = 8'h34;
    sample("r.s1", 3'd1, ctl_fetch());
    tick();
    dbus = 8'h12;
    sample("r.s2", 3'd2, ctl_fetch());
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("r.opcode", 32'(opcode), 32'd0);
    check("r.addr", 32'(addr), 32'd0);
    check("r.step", 32'(step), 32'd0);
    check("r.loadn", 32'(pc_loadn), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    dbus  = 8'h00;
    sample("r.after", 3'd0, ctl_fetch());
    check("r.after.addr", 32'(addr), 32'd0);
    tick();
    sample("r.after.s1", 3'd1, ctl_idle());
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
